// File: rtl/led_pattern_gen.sv
// led_pattern_gen: prescaled LED pattern driver (all-on, blink, binary count, chaser).
// Define LED_PWM_EN to add the brightness port and PWM dimming of the LED outputs.
module led_pattern_gen #(
    parameter int unsigned NUM_LEDS = 2,
    parameter int unsigned TICK_DIV = 12000000
`ifdef LED_PWM_EN
    ,
    parameter int unsigned PWM_W    = 4
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          mode,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]    brightness,
`endif
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_ALL_ON = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_e;

    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [NUM_LEDS-1:0] pattern_q, pattern_d;
    mode_e               cur_mode_q, cur_mode_d;
    logic                loaded_q, loaded_d;
    logic                tick_q, tick_d;
    logic                load_c;

    function automatic logic [NUM_LEDS-1:0] init_pattern(input mode_e m);
        case (m)
            MODE_COUNT: return '0;
            MODE_CHASE: return NUM_LEDS'(1);
            default:    return '1;
        endcase
    endfunction

    // Rotate via shift pair so a single-LED chaser keeps its one bit lit.
    function automatic logic [NUM_LEDS-1:0] next_pattern(input mode_e m,
                                                         input logic [NUM_LEDS-1:0] p);
        case (m)
            MODE_BLINK: return ~p;
            MODE_COUNT: return p + NUM_LEDS'(1);
            MODE_CHASE: return (p << 1) | (p >> (NUM_LEDS - 1));
            default:    return p;
        endcase
    endfunction

    // A fresh mode (or first cycle after reset) reloads the pattern ahead of any step.
    assign load_c = !loaded_q || (mode_e'(mode) != cur_mode_q);

    always_comb begin
        presc_d    = presc_q;
        pattern_d  = pattern_q;
        cur_mode_d = cur_mode_q;
        loaded_d   = loaded_q;
        tick_d     = 1'b0;
        if (load_c) begin
            cur_mode_d = mode_e'(mode);
            pattern_d  = init_pattern(mode_e'(mode));
            presc_d    = '0;
            loaded_d   = 1'b1;
        end else if (enable) begin
            if (presc_q == PRESC_MAX) begin
                presc_d   = '0;
                pattern_d = next_pattern(cur_mode_q, pattern_q);
                tick_d    = 1'b1;
            end else begin
                presc_d = presc_q + PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            pattern_q  <= '0;
            cur_mode_q <= MODE_ALL_ON;
            loaded_q   <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            pattern_q  <= pattern_d;
            cur_mode_q <= cur_mode_d;
            loaded_q   <= loaded_d;
            tick_q     <= tick_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic             pwm_on_c;

    always_comb begin
        pwm_cnt_d = pwm_cnt_q;
        if (enable) begin
            pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    // Full-scale brightness bypasses the comparator so the LEDs never blink off.
    assign pwm_on_c = (brightness == '1) || (pwm_cnt_q < brightness);
    assign leds     = (enable && loaded_q && pwm_on_c) ? pattern_q : '0;
`else
    assign leds     = (enable && loaded_q) ? pattern_q : '0;
`endif

    assign tick = tick_q & enable;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen (NUM_LEDS=4, TICK_DIV=4).
// Define LED_PWM_EN to also exercise the brightness feature.
module tb_led_pattern_gen;
    localparam int unsigned N  = 4;
    localparam int unsigned TD = 4;
`ifdef LED_PWM_EN
    localparam int unsigned PW = 4;
    logic [PW-1:0] brightness = '1;
    logic [PW-1:0] m_pwm;
`endif

    typedef struct packed {
        logic [N-1:0] leds;
        logic         tick;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic [1:0]   mode;
    logic [N-1:0] leds;
    logic         tick;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    int           m_presc;
    logic [N-1:0] m_pat;
    logic [1:0]   m_mode;
    logic         m_loaded;
    logic         m_tick;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .NUM_LEDS(N),
        .TICK_DIV(TD)
`ifdef LED_PWM_EN
        ,
        .PWM_W(PW)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .mode(mode),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .leds(leds),
        .tick(tick)
    );

    function automatic logic [N-1:0] m_init(input logic [1:0] m);
        case (m)
            2'd2:    return 4'b0000;
            2'd3:    return 4'b0001;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [N-1:0] m_next(input logic [1:0] m, input logic [N-1:0] p);
        case (m)
            2'd1:    return ~p;
            2'd2:    return p + 4'd1;
            2'd3:    return {p[N-2:0], p[N-1]};
            default: return p;
        endcase
    endfunction

    // Reference model: samples stimulus at each edge and queues the expected outputs.
    always @(posedge clk) begin : model
        exp_t e;
        if (rst) begin
            m_presc = 0; m_pat = '0; m_mode = 2'd0; m_loaded = 1'b0; m_tick = 1'b0;
`ifdef LED_PWM_EN
            m_pwm = '0;
`endif
        end else begin
            if (!m_loaded || mode != m_mode) begin
                m_mode = mode; m_pat = m_init(mode); m_presc = 0; m_loaded = 1'b1; m_tick = 1'b0;
            end else if (enable) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0; m_pat = m_next(m_mode, m_pat); m_tick = 1'b1;
                end else begin
                    m_presc = m_presc + 1; m_tick = 1'b0;
                end
            end else begin
                m_tick = 1'b0;
            end
`ifdef LED_PWM_EN
            if (enable) m_pwm = m_pwm + 1'b1;
`endif
        end
        e.leds = (enable && m_loaded) ? m_pat : '0;
`ifdef LED_PWM_EN
        if (!(brightness == '1 || m_pwm < brightness)) e.leds = '0;
`endif
        e.tick = m_tick && enable;
        exp_q.push_back(e);
    end

    task automatic adv();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) cur = 'x;
        else cur = exp_q.pop_front();
    endtask

    task automatic test_reset();
        int nt = 0;
        rst = 1'b1; enable = 1'b1; mode = 2'd0;
        adv(); adv();
        checks++; if (leds !== 4'b0000 || tick !== 1'b0) begin errors++; $display("FAIL reset_hold leds=%b tick=%b want 0000/0", leds, tick); end
        rst = 1'b0; #1;
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL reset_release leds=%b want 0000", leds); end
        adv();
        checks++; if (leds !== 4'b1111 || tick !== 1'b0) begin errors++; $display("FAIL all_on_load leds=%b tick=%b want 1111/0", leds, tick); end
        for (int i = 0; i < 16; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_all_on leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
            checks++; if (leds !== 4'b1111) begin errors++; $display("FAIL all_on_const leds=%b want 1111", leds); end
            if (tick === 1'b1) nt++;
        end
        checks++; if (nt != 4) begin errors++; $display("FAIL all_on_ticks count=%0d want 4", nt); end
    endtask

    task automatic test_count();
        int k = 0;
        rst = 1'b1; mode = 2'd2;
        adv();
        rst = 1'b0;
        adv();
        checks++; if (leds !== 4'b0000 || tick !== 1'b0) begin errors++; $display("FAIL count_init leds=%b tick=%b want 0000/0", leds, tick); end
        for (int i = 0; i < 17 * TD; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_count leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
            if (tick === 1'b1) begin
                k++;
                checks++; if (leds !== 4'(k)) begin errors++; $display("FAIL count_step leds=%b want %b", leds, 4'(k)); end
            end
        end
        checks++; if (k != 17) begin errors++; $display("FAIL count_ticks count=%0d want 17", k); end
    endtask

    task automatic test_chase_blink();
        logic [N-1:0] seq [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int k = 0;
        mode = 2'd3;
        adv();
        checks++; if (leds !== 4'b0001) begin errors++; $display("FAIL chase_init leds=%b want 0001", leds); end
        for (int i = 0; i < 4 * TD; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_chase leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
            if (tick === 1'b1 && k < 4) begin
                checks++; if (leds !== seq[k]) begin errors++; $display("FAIL chase_step leds=%b want %b", leds, seq[k]); end
                k++;
            end
        end
        checks++; if (k != 4) begin errors++; $display("FAIL chase_ticks count=%0d want 4", k); end
        adv(); adv();
        mode = 2'd1;
        adv();
        checks++; if (leds !== 4'b1111 || tick !== 1'b0) begin errors++; $display("FAIL blink_load leds=%b tick=%b want 1111/0", leds, tick); end
        for (int i = 0; i < TD; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_blink leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
        end
        checks++; if (leds !== 4'b0000 || tick !== 1'b1) begin errors++; $display("FAIL blink_step leds=%b tick=%b want 0000/1", leds, tick); end
    endtask

    task automatic test_pause();
        mode = 2'd2;
        adv();
        for (int i = 0; i < 3 * TD; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_pause_run leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
        end
        checks++; if (leds !== 4'b0011 || tick !== 1'b1) begin errors++; $display("FAIL pause_reach leds=%b tick=%b want 0011/1", leds, tick); end
        adv();
        enable = 1'b0; #1;
        checks++; if (leds !== 4'b0000 || tick !== 1'b0) begin errors++; $display("FAIL pause_off leds=%b tick=%b want 0000/0", leds, tick); end
        for (int i = 0; i < 10; i++) begin
            adv();
            checks++; if (leds !== 4'b0000 || tick !== 1'b0 || leds !== cur.leds) begin errors++; $display("FAIL pause_hold leds=%b tick=%b want 0000/0", leds, tick); end
        end
        enable = 1'b1; #1;
        checks++; if (leds !== 4'b0011) begin errors++; $display("FAIL pause_resume leds=%b want 0011", leds); end
        for (int i = 0; i < 2; i++) begin
            adv();
            checks++; if (leds !== 4'b0011 || tick !== 1'b0) begin errors++; $display("FAIL pause_remain leds=%b tick=%b want 0011/0", leds, tick); end
        end
        adv();
        checks++; if (leds !== 4'b0100 || tick !== 1'b1) begin errors++; $display("FAIL pause_step leds=%b tick=%b want 0100/1", leds, tick); end
    endtask

    task automatic test_reset_mid();
        mode = 2'd3;
        adv();
        for (int i = 0; i < 2 * TD; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_rst_mid leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
        end
        checks++; if (leds !== 4'b0100) begin errors++; $display("FAIL rst_mid_reach leds=%b want 0100", leds); end
        rst = 1'b1;
        adv();
        checks++; if (leds !== 4'b0000 || tick !== 1'b0) begin errors++; $display("FAIL rst_mid_clear leds=%b tick=%b want 0000/0", leds, tick); end
        rst = 1'b0; #1;
        checks++; if (leds !== 4'b0000) begin errors++; $display("FAIL rst_mid_release leds=%b want 0000", leds); end
        adv();
        checks++; if (leds !== 4'b0001 || tick !== 1'b0) begin errors++; $display("FAIL rst_mid_reload leds=%b tick=%b want 0001/0", leds, tick); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] want [4] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001};
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            adv();
            checks++; if (leds !== want[m] || tick !== 1'b0 || leds !== cur.leds) begin errors++; $display("FAIL b2b_load mode=%0d leds=%b tick=%b want %b/0", m, leds, tick, want[m]); end
        end
        for (int i = 0; i < TD; i++) begin
            adv();
            checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_b2b leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
        end
        checks++; if (leds !== 4'b0010 || tick !== 1'b1) begin errors++; $display("FAIL b2b_step leds=%b tick=%b want 0010/1", leds, tick); end
    endtask

`ifdef LED_PWM_EN
    task automatic test_pwm();
        logic [PW-1:0] lvl [3] = '{4'd4, 4'd15, 4'd0};
        int            want [3] = '{8, 32, 0};
        mode = 2'd0;
        adv();
        for (int b = 0; b < 3; b++) begin
            int on = 0;
            brightness = lvl[b];
            for (int i = 0; i < 32; i++) begin
                adv();
                checks++; if (leds !== cur.leds || tick !== cur.tick) begin errors++; $display("FAIL sb_pwm leds=%b tick=%b want %b/%b", leds, tick, cur.leds, cur.tick); end
                if (leds[0] === 1'b1) on++;
            end
            checks++; if (on != want[b]) begin errors++; $display("FAIL pwm_duty brightness=%0d on=%0d want %0d", lvl[b], on, want[b]); end
        end
        brightness = '1;
    endtask
`endif

    initial begin
        rst = 1'b1; enable = 1'b1; mode = 2'd0;
        test_reset();
        test_count();
        test_chase_blink();
        test_pause();
        test_reset_mid();
        test_back_to_back();
`ifdef LED_PWM_EN
        test_pwm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
